// File: rtl/program_sequencer_if.sv
// Control and status bundle of the program sequencer.
// All controls are per-cycle levels with no valid/ready handshake: the
// sequencer samples every input on each rising clk edge, and hold=1 freezes
// it for that cycle. pm_addr is combinational. pc, sp_count and the two
// sticky flags are registered.
interface program_sequencer_if #(
   parameter int STACK_DEPTH = 4
);
   localparam int SPW = $clog2(STACK_DEPTH) + 1;

   logic           hold;
   logic           jmp;
   logic           jmp_nz;
   logic           dont_jmp;
   logic [3:0]     jmp_addr;
   logic           call;
   logic           ret;
   logic [7:0]     pm_addr;
   logic [7:0]     pc;
   logic [SPW-1:0] sp_count;
   logic           stack_ovf;
   logic           stack_unf;

   // Decoder side: issues requests and observes fetch address and stack status
   modport master (
      output hold, jmp, jmp_nz, dont_jmp, jmp_addr, call, ret,
      input  pm_addr, pc, sp_count, stack_ovf, stack_unf
   );

   // Sequencer side
   modport slave (
      input  hold, jmp, jmp_nz, dont_jmp, jmp_addr, call, ret,
      output pm_addr, pc, sp_count, stack_ovf, stack_unf
   );
endinterface

// File: rtl/program_sequencer.sv
// Program sequencer: produces the next program-memory fetch address and
// keeps a small return-address stack for call/ret. Jumps and calls stay
// inside the current 16-word page. Only ret or sequential increment can
// cross into another page.
module program_sequencer #(
   parameter int STACK_DEPTH = 4
) (
   input  logic                clk,
   input  logic                sync_reset_n,
   program_sequencer_if.slave  bus
);
   localparam int              PW      = $clog2(STACK_DEPTH);
   localparam int              SPW     = PW + 1;
   localparam logic [SPW-1:0]  SP_ONE  = SPW'(1);
   localparam logic [SPW-1:0]  SP_FULL = SPW'(STACK_DEPTH);

   logic [7:0]     r_pc;
   logic [SPW-1:0] r_sp;
   logic           r_ovf;
   logic           r_unf;
   logic [7:0]     r_stack [STACK_DEPTH];

   logic [7:0]     w_pc_inc;
   logic [7:0]     w_target;
   logic [PW-1:0]  w_top_idx;
   logic [PW-1:0]  w_push_idx;
   logic [7:0]     w_top;
   logic           w_active;
   logic           w_nonempty;
   logic           w_full;
   logic           w_do_call;
   logic           w_push;
   logic           w_pop;
   logic           w_ovf_evt;
   logic           w_unf_evt;
   logic [7:0]     w_pm_addr;

   assign w_pc_inc   = r_pc + 8'd1;                // wraps FF -> 00 silently
   assign w_target   = {r_pc[7:4], bus.jmp_addr};  // page-relative target
   assign w_nonempty = (r_sp != '0);
   assign w_full     = (r_sp == SP_FULL);
   // Top entry sits one below the count. It is only used when the stack is
   // non-empty, so stale entries above sp are never forwarded.
   assign w_top_idx  = r_sp[PW-1:0] - PW'(1);
   assign w_push_idx = r_sp[PW-1:0];
   assign w_top      = r_stack[w_top_idx];

   // Stack and flag events only happen on a live, unfrozen cycle.
   // ret dominates call, so call+ret never pushes or flags overflow.
   assign w_active   = sync_reset_n && !bus.hold;
   assign w_do_call  = w_active && bus.call && !bus.ret;
   assign w_push     = w_do_call && !w_full;
   assign w_ovf_evt  = w_do_call && w_full;
   assign w_pop      = w_active && bus.ret && w_nonempty;
   assign w_unf_evt  = w_active && bus.ret && !w_nonempty;

   // Next fetch address, highest priority first
   always_comb begin
      w_pm_addr = w_pc_inc;
      if (!sync_reset_n) begin
         w_pm_addr = 8'h00;
      end else if (bus.hold) begin
         w_pm_addr = r_pc;
      end else if (bus.ret) begin
         if (w_nonempty) begin
            w_pm_addr = w_top;
         end
      end else if (bus.call || bus.jmp || (bus.jmp_nz && !bus.dont_jmp)) begin
         w_pm_addr = w_target;
      end
   end

   // pc, stack pointer and sticky error flags
   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         r_pc  <= 8'h00;
         r_sp  <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else if (!bus.hold) begin
         r_pc <= w_pm_addr;
         if (w_push) begin
            r_sp <= r_sp + SP_ONE;
         end else if (w_pop) begin
            r_sp <= r_sp - SP_ONE;
         end
         if (w_ovf_evt) begin
            r_ovf <= 1'b1;
         end
         if (w_unf_evt) begin
            r_unf <= 1'b1;
         end
      end
   end

   // Return-address storage. Contents survive reset because the count is
   // what defines validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_stack[w_push_idx] <= w_pc_inc;
      end
   end

   assign bus.pm_addr   = w_pm_addr;
   assign bus.pc        = r_pc;
   assign bus.sp_count  = r_sp;
   assign bus.stack_ovf = r_ovf;
   assign bus.stack_unf = r_unf;
endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter STACK_DEPTH, default 4, number of return-address entries (power of two, 2..16).
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 sync_reset_n  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-004 hold  input  1  freezes the sequencer for the cycle.
REQ-005 jmp  input  1  unconditional jump request.
REQ-006 jmp_nz  input  1  conditional jump request.
REQ-007 dont_jmp  input  1  zero-flag qualifier; jmp_nz is taken only when 0.
REQ-008 jmp_addr  input  4  low nibble of the jump/call target.
REQ-009 call  input  1  subroutine call request (push return address, then jump).
REQ-010 ret  input  1  subroutine return request (pop return address).
REQ-011 pm_addr  output  8  combinational program-memory address for the next fetch.
REQ-012 pc  output  8  registered address of the instruction currently being latched by the decoder.
REQ-013 sp_count  output  log2(STACK_DEPTH)+1  number of occupied stack entries.
REQ-014 stack_ovf  output  1  sticky flag: call attempted with the stack full.
REQ-015 stack_unf  output  1  sticky flag: ret attempted with the stack empty.

Function
REQ-016 pc SHALL load pm_addr on every rising edge unless hold=1 or reset is active; pm_addr SHALL be the only source of pc.
REQ-017 Jump target SHALL be {pc[7:4], jmp_addr}; no page change is possible via jmp, jmp_nz or call.
REQ-018 pm_addr selection, highest priority first: reset -> 8'h00; hold -> pc; ret with sp_count>0 -> top of stack; call -> target; jmp -> target; jmp_nz with dont_jmp=0 -> target; otherwise -> pc+1.
REQ-019 pc+1 SHALL wrap from 8'hFF to 8'h00 without a flag.
REQ-020 call with sp_count<STACK_DEPTH SHALL push pc+1 (wrapped) and increment sp_count on the same edge that pc loads the target.
REQ-021 call with sp_count=STACK_DEPTH SHALL still jump to the target, push nothing, leave sp_count unchanged and set stack_ovf.
REQ-022 ret with sp_count>0 SHALL pop the top entry into pc and decrement sp_count on the same edge.
REQ-023 ret with sp_count=0 SHALL select pc+1, leave sp_count at 0 and set stack_unf.
REQ-024 ret and call asserted together SHALL perform ret only; call is ignored and does not set stack_ovf.
REQ-025 jmp, jmp_nz and call asserted together SHALL perform call only (one push).
REQ-026 hold=1 SHALL ignore all control inputs: no push, no pop, no flag update, pc and sp_count unchanged.
REQ-027 jmp_nz with dont_jmp=1 SHALL behave exactly as no request (pc+1).
REQ-028 Latency: a request sampled with pc=P appears on pm_addr combinationally in the same cycle and on pc at the next edge; one instruction of delay to the decoder's ir.
REQ-029 stack_ovf and stack_unf SHALL remain set until reset; no other input clears them.
REQ-030 Stack entries above sp_count SHALL never be observable on pm_addr.

Reset
REQ-031 While sync_reset_n=0 at an edge: pc<=8'h00, sp_count<=0, stack_ovf<=0, stack_unf<=0; stack contents need not be cleared.
REQ-032 pm_addr SHALL be 8'h00 combinationally whenever sync_reset_n=0, regardless of hold or requests.
REQ-033 Reset asserted mid-subroutine SHALL discard all stacked return addresses; a subsequent ret SHALL set stack_unf.
REQ-034 First edge after reset release SHALL load pc=8'h01 unless a request is present.

Verification
REQ-035 Release reset, no requests for 300 cycles -> pc runs 00,01,...,FF,00,... and no flag sets.
REQ-036 pc=8'h37, jmp=1, jmp_addr=4'hA -> pm_addr=8'h3A same cycle, pc=8'h3A next cycle; repeat with jmp_nz=1,dont_jmp=1 -> pc=8'h38.
REQ-037 pc=8'h10 call addr 4'h5, then pc=8'h15 call addr 4'h9, then two rets -> pc sequence 15,19,16,11; sp_count 1,2,1,0.
REQ-038 Five calls with STACK_DEPTH=4 -> sp_count saturates at 4, stack_ovf=1 after fifth, fifth still jumps; then ret on empty stack after four pops -> stack_unf=1, pc advances by 1.
REQ-039 hold=1 for 3 cycles with call=1 and ret=1 -> pm_addr=pc, pc and sp_count unchanged, no flags.
REQ-040 Two calls then reset pulse for one edge -> pc=8'h00, sp_count=0, flags 0; next ret sets stack_unf.
